// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types for the branch/PC stage.
//   br_funct3_e : B-type funct3 encodings (010/011 are reserved)
//   pc_state_e  : boot/run/trap sequencing of the PC stage
//   PC_STEP     : sequential fetch increment
package rv32_pkg;

  typedef enum logic [2:0] {
    BEQ   = 3'b000,
    BNE   = 3'b001,
    BRSV2 = 3'b010,
    BRSV3 = 3'b011,
    BLT   = 3'b100,
    BGE   = 3'b101,
    BLTU  = 3'b110,
    BGEU  = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_branch_ctrl_branch_decide.sv
// branch_decide: combinational B-type condition decode.
//   funct3   in  3  instruction funct3
//   br_equal in  1  rs1 == rs2
//   br_less  in  1  rs1 < rs2 (signedness selected by br_un)
//   taken    out 1  condition true for a legal B-type funct3
//   illegal  out 1  funct3 is a reserved B-type encoding (010/011)
//   br_un    out 1  unsigned compare request, funct3[1]
module branch_decide
  import rv32_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       br_equal,
  input  logic       br_less,
  output logic       taken,
  output logic       illegal,
  output logic       br_un
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    br_un   = funct3[1];
    case (br_funct3_e'(funct3))
      BEQ:        taken = br_equal;
      BNE:        taken = ~br_equal;
      BLT, BLTU:  taken = br_less;
      BGE, BGEU:  taken = ~br_less;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: branch resolution, PC register and boot/run/trap sequencing.
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_stall                 freeze PC, state, EPC and counters
//   i_is_branch/jal/jalr    instruction class (priority jalr > jal > branch)
//   i_funct3, i_br_equal, i_br_less  branch condition inputs
//   i_target                ALU-computed transfer target
//   o_br_un                 unsigned compare request to brcomp
//   o_pc, o_pc_four         fetch address and link value
//   o_pc_valid              o_pc is a real fetch address (not BOOT)
//   o_taken, o_illegal_br, o_misalign  per-cycle decode results
//   o_epc                   PC of the last trapping instruction
// Optional: define BR_PERF_CNT_EN to add o_br_cnt / o_br_taken_cnt.
module pc_branch_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_is_branch,
  input  logic        i_is_jal,
  input  logic        i_is_jalr,
  input  logic [2:0]  i_funct3,
  input  logic        i_br_equal,
  input  logic        i_br_less,
  input  logic [31:0] i_target,
  output logic        o_br_un,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_pc_valid,
  output logic        o_taken,
  output logic        o_illegal_br,
  output logic        o_misalign,
  output logic [31:0] o_epc
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_br_taken_cnt
`endif
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        dec_taken, dec_illegal, dec_br_un;
  logic        active, sel_branch;
  logic [31:0] eff_target;

  branch_decide u_decide (
    .funct3   (i_funct3),
    .br_equal (i_br_equal),
    .br_less  (i_br_less),
    .taken    (dec_taken),
    .illegal  (dec_illegal),
    .br_un    (dec_br_un)
  );

  assign active     = (state_q != BOOT);
  assign sel_branch = i_is_branch & ~i_is_jal & ~i_is_jalr;
  assign eff_target = {i_target[31:1], i_target[0] & ~i_is_jalr};

  assign o_pc       = pc_q;
  assign o_pc_four  = pc_q + PC_STEP;
  assign o_pc_valid = active;
  assign o_epc      = epc_q;

  // Decode outputs are forced low during the boot bubble.
  always_comb begin
    o_br_un      = active & dec_br_un;
    o_taken      = active & (i_is_jalr | i_is_jal | (sel_branch & dec_taken));
    o_illegal_br = active & sel_branch & dec_illegal;
    o_misalign   = o_taken & (eff_target[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    if (!i_stall) begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN, TRAP: begin
          if (o_misalign) begin
            epc_d   = pc_q;
            pc_d    = TRAP_VEC;
            state_d = TRAP;
          end else begin
            pc_d    = o_taken ? eff_target : o_pc_four;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

`ifdef BR_PERF_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_br_cnt       <= '0;
      o_br_taken_cnt <= '0;
    end else if (!i_stall && active && i_is_branch) begin
      o_br_cnt <= o_br_cnt + 32'd1;
      if (o_taken) o_br_taken_cnt <= o_br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_is_branch, i_is_jal, i_is_jalr;
  logic [2:0]  i_funct3;
  logic        i_br_equal, i_br_less;
  logic [31:0] i_target;
  logic        o_br_un, o_pc_valid, o_taken, o_illegal_br, o_misalign;
  logic [31:0] o_pc, o_pc_four, o_epc;
`ifdef BR_PERF_CNT_EN
  logic [31:0] o_br_cnt, o_br_taken_cnt;
`endif

  pc_branch_ctrl #(.RESET_VEC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_stall      (i_stall),
    .i_is_branch  (i_is_branch),
    .i_is_jal     (i_is_jal),
    .i_is_jalr    (i_is_jalr),
    .i_funct3     (i_funct3),
    .i_br_equal   (i_br_equal),
    .i_br_less    (i_br_less),
    .i_target     (i_target),
    .o_br_un      (o_br_un),
    .o_pc         (o_pc),
    .o_pc_four    (o_pc_four),
    .o_pc_valid   (o_pc_valid),
    .o_taken      (o_taken),
    .o_illegal_br (o_illegal_br),
    .o_misalign   (o_misalign),
    .o_epc        (o_epc)
`ifdef BR_PERF_CNT_EN
    ,
    .o_br_cnt       (o_br_cnt),
    .o_br_taken_cnt (o_br_taken_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        st, br, jal, jalr;
    logic [2:0]  f3;
    logic        eq, lt;
    logic [31:0] tgt;
    logic [3:0]  dec;   // {br_un, taken, illegal, misalign} during the cycle
    logic [31:0] pc;    // o_pc after the edge
    logic [31:0] epc;   // o_epc after the edge
    logic        vld;   // o_pc_valid after the edge
  } vec_t;

  typedef struct {
    logic [31:0] pc, epc;
    logic        vld;
  } exp_t;

  vec_t vecs[$];
  vec_t boot_vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_vld;

  function automatic vec_t mk(input logic st, br, jal, jalr, input logic [2:0] f3,
                              input logic eq, lt, input logic [31:0] tgt,
                              input logic [3:0] dec, input logic [31:0] pc, epc,
                              input logic vld);
    vec_t v;
    v.st = st; v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
    v.eq = eq; v.lt = lt; v.tgt = tgt; v.dec = dec;
    v.pc = pc; v.epc = epc; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge i_clk);
    i_stall = v.st; i_is_branch = v.br; i_is_jal = v.jal; i_is_jalr = v.jalr;
    i_funct3 = v.f3; i_br_equal = v.eq; i_br_less = v.lt; i_target = v.tgt;
    #1;
    chk({tag, " decode"}, {28'd0, o_br_un, o_taken, o_illegal_br, o_misalign}, {28'd0, v.dec});
    chk({tag, " valid_now"}, {31'd0, o_pc_valid}, {31'd0, prev_vld});
    e.pc = v.pc; e.epc = v.epc; e.vld = v.vld;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, " pc"}, o_pc, e.pc);
      chk({tag, " pc_four"}, o_pc_four, e.pc + 32'd4);
      chk({tag, " epc"}, o_epc, e.epc);
      chk({tag, " valid"}, {31'd0, o_pc_valid}, {31'd0, e.vld});
      prev_vld = e.vld;
    end
  endtask

  task automatic idle_inputs;
    i_stall = 0; i_is_branch = 0; i_is_jal = 0; i_is_jalr = 0;
    i_funct3 = 3'b000; i_br_equal = 0; i_br_less = 0; i_target = '0;
  endtask

  initial begin
    // main sequence: starts in BOOT right after reset release
    vecs.push_back(mk(0,0,1,0,3'b110,0,0,32'h40,       4'b0000, 32'h0,        32'h0,    1));
    vecs.push_back(mk(0,0,0,0,3'b000,0,0,32'h0,        4'b0000, 32'h4,        32'h0,    1));
    vecs.push_back(mk(0,0,0,0,3'b000,0,0,32'h0,        4'b0000, 32'h8,        32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b000,1,0,32'h40,       4'b0100, 32'h40,       32'h0,    1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'h8,        4'b0100, 32'h8,        32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b000,0,0,32'h40,       4'b0000, 32'hC,        32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b110,0,1,32'h200,      4'b1100, 32'h200,      32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b101,0,1,32'h300,      4'b0000, 32'h204,      32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b010,1,0,32'h300,      4'b1010, 32'h208,      32'h0,    1));
    vecs.push_back(mk(0,1,0,0,3'b001,0,0,32'h20,       4'b0100, 32'h20,       32'h0,    1));
    vecs.push_back(mk(0,0,0,1,3'b000,0,0,32'h103,      4'b0101, 32'h100,      32'h20,   1));
    vecs.push_back(mk(0,0,0,0,3'b000,0,0,32'h0,        4'b0000, 32'h104,      32'h20,   1));
    vecs.push_back(mk(0,1,0,0,3'b100,0,0,32'h10,       4'b0000, 32'h108,      32'h20,   1));
    vecs.push_back(mk(0,1,0,0,3'b111,0,0,32'h1000,     4'b1100, 32'h1000,     32'h20,   1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'h2002,     4'b0101, 32'h100,      32'h1000, 1));
    vecs.push_back(mk(0,0,0,1,3'b000,0,0,32'h55,       4'b0100, 32'h54,       32'h1000, 1));
    vecs.push_back(mk(0,1,0,0,3'b000,1,0,32'h6,        4'b0101, 32'h100,      32'h54,   1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'h201,      4'b0101, 32'h100,      32'h100,  1));
    vecs.push_back(mk(0,1,1,0,3'b010,0,0,32'h300,      4'b1100, 32'h300,      32'h100,  1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'hFFFF_FFFC,4'b0100, 32'hFFFF_FFFC,32'h100,  1));
    vecs.push_back(mk(0,0,0,0,3'b000,0,0,32'h0,        4'b0000, 32'h0,        32'h100,  1));
    vecs.push_back(mk(1,0,1,0,3'b000,0,0,32'h80,       4'b0100, 32'h0,        32'h100,  1));
    vecs.push_back(mk(1,0,1,0,3'b000,0,0,32'h80,       4'b0100, 32'h0,        32'h100,  1));
    vecs.push_back(mk(1,0,1,0,3'b000,0,0,32'h80,       4'b0100, 32'h0,        32'h100,  1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'h80,       4'b0100, 32'h80,       32'h100,  1));
    vecs.push_back(mk(1,0,1,0,3'b000,0,0,32'h81,       4'b0101, 32'h80,       32'h100,  1));
    vecs.push_back(mk(0,0,1,0,3'b000,0,0,32'h81,       4'b0101, 32'h100,      32'h80,   1));

    // after a mid-stall reset: boot bubble, then 5 counted branches (3 taken)
    boot_vecs.push_back(mk(0,0,0,0,3'b000,0,0,32'h0,   4'b0000, 32'h0,  32'h0, 1));
    boot_vecs.push_back(mk(0,1,0,0,3'b000,1,0,32'h10,  4'b0100, 32'h10, 32'h0, 1));
    boot_vecs.push_back(mk(0,1,0,0,3'b001,1,0,32'h40,  4'b0000, 32'h14, 32'h0, 1));
    boot_vecs.push_back(mk(1,1,0,0,3'b100,0,1,32'h30,  4'b0100, 32'h14, 32'h0, 1));
    boot_vecs.push_back(mk(0,1,0,0,3'b100,0,1,32'h30,  4'b0100, 32'h30, 32'h0, 1));
    boot_vecs.push_back(mk(0,1,0,0,3'b101,0,1,32'h80,  4'b0000, 32'h34, 32'h0, 1));
    boot_vecs.push_back(mk(0,1,0,0,3'b110,0,1,32'h8,   4'b1100, 32'h8,  32'h0, 1));

    // power-on reset with a JAL presented: everything stays gated
    idle_inputs();
    i_is_jal = 1; i_target = 32'h40;
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("por pc", o_pc, 32'h0);
    chk("por valid", {31'd0, o_pc_valid}, 32'd0);
    chk("por epc", o_epc, 32'h0);
    chk("por taken", {31'd0, o_taken}, 32'd0);
    i_reset = 0;
    prev_vld = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

    // async reset while stalled in TRAP with a taken JAL pending
    @(negedge i_clk);
    i_stall = 1; i_is_branch = 0; i_is_jalr = 0; i_is_jal = 1; i_target = 32'h80;
    #2;
    i_reset = 1;
    #1;
    chk("async_rst pc", o_pc, 32'h0);
    chk("async_rst valid", {31'd0, o_pc_valid}, 32'd0);
    chk("async_rst epc", o_epc, 32'h0);
    chk("async_rst taken", {31'd0, o_taken}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("rst_hold pc", o_pc, 32'h0);
    i_reset = 0;
    prev_vld = 1'b0;

    for (int i = 0; i < boot_vecs.size(); i++) step(boot_vecs[i], $sformatf("b%0d", i));

`ifdef BR_PERF_CNT_EN
    chk("br_cnt", o_br_cnt, 32'd5);
    chk("br_taken_cnt", o_br_taken_cnt, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
